// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: CSI-2 data-type codes, receiver state encoding and header ECC.
package mipi_csi_pkg;
  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_LONG = 6'h10;
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR0    = 4'd1;
  localparam logic [3:0] ST_HDR1    = 4'd2;
  localparam logic [3:0] ST_HDR2    = 4'd3;
  localparam logic [3:0] ST_HDR3    = 4'd4;
  localparam logic [3:0] ST_PAYLOAD = 4'd5;
  localparam logic [3:0] ST_CRC0    = 4'd6;
  localparam logic [3:0] ST_CRC1    = 4'd7;
  localparam logic [3:0] ST_DRAIN   = 4'd8;
  // each mask selects the header bits {WC[15:0], DataID[7:0]} covered by one parity bit
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
endpackage

// File: rtl/mipi_csi_crc16.sv
// mipi_csi_crc16: byte-wide CRC-16 (x^16+x^12+x^5+1, reflected, init 0xFFFF) for CSI-2 payloads.
module mipi_csi_crc16 (
  input  logic        clk,
  input  logic        resetb,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    return r;
  endfunction
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) crc <= 16'hFFFF;
    else crc <= init ? 16'hFFFF : en ? crc_byte(crc, data) : crc;
endmodule

// File: rtl/mipi_csi_rx_packet.sv
// mipi_csi_rx_packet: CSI-2 byte-stream packet parser (sync, header ECC, payload, CRC).
// Payload CRC checking is built only when MIPI_CSI_CRC_CHECK_EN is defined.
module mipi_csi_rx_packet
  import mipi_csi_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = 8'hB8,
  parameter logic [15:0] MAX_WC    = 16'd8192
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       in_we,
  input  logic [7:0] in_data,
  output logic       frame_valid,
  output logic       line_valid,
  output logic       pix_we,
  output logic [7:0] pix_data,
  output logic [5:0] data_type,
  output logic [1:0] vc,
  output logic [3:0] err
);
  logic [3:0]  state;
  logic [7:0]  did;
  logic [15:0] wc;
  logic [15:0] rem;
  logic [2:0]  err_r;
  logic        crc_err;
  logic        ecc_ok;
  logic        is_short;
  logic        busy;
  always_comb begin
    ecc_ok   = csi_ecc({wc, did}) == in_data[5:0];
    is_short = did[5:0] < DT_LONG;
    busy     = state >= ST_HDR0 && state <= ST_CRC1;
  end
  assign err = {crc_err, err_r};
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state       <= ST_IDLE;
      did         <= '0;
      wc          <= '0;
      rem         <= '0;
      err_r       <= '0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      pix_we      <= 1'b0;
      pix_data    <= '0;
      data_type   <= '0;
      vc          <= '0;
    end else begin
      err_r      <= '0;
      pix_we     <= 1'b0;
      line_valid <= 1'b0;
      // a burst ending before the packet completes is a truncated packet
      if (!in_we) begin
        err_r[2] <= busy;
        state    <= ST_IDLE;
      end else case (state)
        ST_IDLE:
          if (in_data == SYNC_BYTE) state <= ST_HDR0;
          else begin
            err_r[0] <= 1'b1;
            state    <= ST_DRAIN;
          end
        ST_HDR0: begin
          did   <= in_data;
          state <= ST_HDR1;
        end
        ST_HDR1: begin
          wc[7:0] <= in_data;
          state   <= ST_HDR2;
        end
        ST_HDR2: begin
          wc[15:8] <= in_data;
          state    <= ST_HDR3;
        end
        ST_HDR3: begin
          state <= ST_DRAIN;
          if (!ecc_ok) err_r[1] <= 1'b1;
          else begin
            data_type <= did[5:0];
            vc        <= did[7:6];
            if (is_short) frame_valid <= did[5:0] == DT_FS ? 1'b1 : did[5:0] == DT_FE ? 1'b0 : frame_valid;
            else if (wc > MAX_WC) err_r[2] <= 1'b1;
            else if (wc == 16'd0) state <= ST_CRC0;
            else begin
              rem   <= wc;
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          pix_we     <= 1'b1;
          line_valid <= 1'b1;
          pix_data   <= in_data;
          rem        <= rem - 16'd1;
          if (rem == 16'd1) state <= ST_CRC0;
        end
        ST_CRC0: state <= ST_CRC1;
        ST_CRC1: state <= ST_DRAIN;
        default: state <= ST_DRAIN;
      endcase
    end
`ifdef MIPI_CSI_CRC_CHECK_EN
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  mipi_csi_crc16 u_crc (
    .clk    (clk),
    .resetb (resetb),
    .init   (state == ST_IDLE),
    .en     (in_we && state == ST_PAYLOAD),
    .data   (in_data),
    .crc    (crc)
  );
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      crc_lo  <= '0;
      crc_err <= 1'b0;
    end else begin
      crc_lo  <= (in_we && state == ST_CRC0) ? in_data : crc_lo;
      crc_err <= in_we && state == ST_CRC1 && {in_data, crc_lo} != crc;
    end
`else
  assign crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_mipi_csi_rx_packet.sv
// tb_mipi_csi_rx_packet: directed bench for the CSI-2 packet parser; expected
// crc_err depends on MIPI_CSI_CRC_CHECK_EN.
module tb_mipi_csi_rx_packet;
  logic       clk = 1'b0;
  logic       resetb;
  logic       in_we;
  logic [7:0] in_data;
  logic       frame_valid;
  logic       line_valid;
  logic       pix_we;
  logic [7:0] pix_data;
  logic [5:0] data_type;
  logic [1:0] vc;
  logic [3:0] err;
  int         total = 0;
  int         bad = 0;
  int         nlv;
  int         nm;
  logic [3:0] err_acc;
  logic [7:0] q[$];
  logic [7:0] p[$];
  logic [15:0] c;
`ifdef MIPI_CSI_CRC_CHECK_EN
  localparam logic [3:0] CRC_EXP = 4'b1000;
`else
  localparam logic [3:0] CRC_EXP = 4'b0000;
`endif

  mipi_csi_rx_packet dut (
    .clk         (clk),
    .resetb      (resetb),
    .in_we       (in_we),
    .in_data     (in_data),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pix_we      (pix_we),
    .pix_data    (pix_data),
    .data_type   (data_type),
    .vc          (vc),
    .err         (err)
  );

  always #5 clk = ~clk;

  // MSB-first CRC-CCITT on bit-reversed input, result reversed back
  function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
    logic [15:0] s;
    logic [15:0] r;
    logic        fb;
    s = 16'hFFFF;
    foreach (b[k])
      for (int i = 0; i < 8; i++) begin
        fb = s[15] ^ b[k][i];
        s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    for (int i = 0; i < 16; i++) r[i] = s[15-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    nlv = 0;
    err_acc = '0;
    q.delete();
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    in_we = we;
    in_data = d;
    @(posedge clk);
    #1;
    if (pix_we) q.push_back(pix_data);
    if (line_valid) nlv++;
    err_acc |= err;
  endtask

  task automatic hdr(input logic [7:0] id, input logic [15:0] w, input logic [7:0] e);
    step(1'b1, 8'hB8);
    step(1'b1, id);
    step(1'b1, w[7:0]);
    step(1'b1, w[15:8]);
    step(1'b1, e);
  endtask

  task automatic long_body(input logic [7:0] b[$], input logic [15:0] crcv);
    foreach (b[i]) begin
      step(1'b1, b[i]);
      check("payload_out", {pix_we, line_valid, pix_data}, {2'b11, b[i]});
    end
    step(1'b1, crcv[7:0]);
    check("crc0_quiet", {pix_we, line_valid}, 2'b00);
    step(1'b1, crcv[15:8]);
  endtask

  initial begin
    resetb = 1'b0;
    in_we = 1'b0;
    in_data = 8'h00;
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    c = ref_crc(p);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {frame_valid, line_valid, pix_we, pix_data, data_type, vc, err}, 32'd0);
    resetb = 1'b1;
    step(1'b0, 8'h00);
    // frame start
    clear();
    hdr(8'h00, 16'h0001, 8'h1A);
    check("fs_frame_valid", frame_valid, 1'b1);
    step(1'b0, 8'h00);
    check("fs_no_pix", q.size(), 0);
    check("fs_no_err", err_acc, 4'b0000);
    // long packet with corrupted ECC bit 0
    clear();
    hdr(8'h2A, 16'h0004, 8'h32);
    check("ecc_err_pulse", err, 4'b0010);
    foreach (p[i]) step(1'b1, p[i]);
    step(1'b1, c[7:0]);
    step(1'b1, c[15:8]);
    step(1'b0, 8'h00);
    check("ecc_no_pix", q.size(), 0);
    check("ecc_dt_kept", data_type, 6'h00);
    check("ecc_err_only", err_acc, 4'b0010);
    // good long packet
    clear();
    hdr(8'h2A, 16'h0004, 8'h33);
    check("long_dt_vc", {vc, data_type}, 8'h2A);
    long_body(p, c);
    check("long_crc1_err", err, 4'b0000);
    step(1'b0, 8'h00);
    check("long_pix_count", q.size(), 4);
    check("long_lv_cycles", nlv, 4);
    check("long_no_err", err_acc, 4'b0000);
    check("long_fv_kept", frame_valid, 1'b1);
    // CRC MSB corrupted
    clear();
    hdr(8'h2A, 16'h0004, 8'h33);
    long_body(p, c ^ 16'h0100);
    check("crc_err_pulse", err, CRC_EXP);
    step(1'b0, 8'h00);
    // zero word count goes straight to the CRC bytes
    clear();
    hdr(8'h2A, 16'h0000, 8'h10);
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    check("wc0_no_pix", q.size(), 0);
    check("wc0_no_err", err_acc, 4'b0000);
    // word count above MAX_WC
    clear();
    hdr(8'h2A, 16'h3000, 8'h20);
    check("wc_over_len_err", err, 4'b0100);
    step(1'b1, 8'h11);
    step(1'b0, 8'h00);
    check("wc_over_no_pix", q.size(), 0);
    // word count equal to MAX_WC is accepted, then truncated
    clear();
    hdr(8'h2A, 16'h2000, 8'h3F);
    step(1'b1, 8'hAA);
    check("wc_max_pix", {pix_we, pix_data}, 9'h1AA);
    step(1'b0, 8'h00);
    check("wc_max_trunc", err, 4'b0100);
    // bad sync byte, rest of burst ignored
    clear();
    step(1'b1, 8'hB9);
    check("sync_err_pulse", err, 4'b0001);
    step(1'b1, 8'hB8);
    step(1'b1, 8'h2A);
    step(1'b1, 8'h04);
    step(1'b1, 8'h00);
    step(1'b1, 8'h33);
    step(1'b1, 8'h11);
    step(1'b0, 8'h00);
    check("sync_ignored_pix", q.size(), 0);
    check("sync_err_only", err_acc, 4'b0001);
    // WC 100 truncated after 50 payload bytes
    clear();
    hdr(8'h2A, 16'd100, 8'h30);
    for (int i = 1; i <= 50; i++) step(1'b1, 8'(i));
    step(1'b0, 8'h00);
    check("drop_len_err", err, 4'b0100);
    check("drop_lv_low", {line_valid, pix_we}, 2'b00);
    check("drop_pix_count", q.size(), 50);
    check("drop_lv_cycles", nlv, 50);
    nm = 0;
    foreach (q[i]) if (q[i] != 8'(i + 1)) nm++;
    check("drop_pix_data", nm, 0);
    // back in IDLE: frame end accepted
    clear();
    hdr(8'h01, 16'h0001, 8'h1D);
    check("fe_frame_valid", frame_valid, 1'b0);
    check("fe_dt", data_type, 6'h01);
    step(1'b0, 8'h00);
    // asynchronous reset mid-burst, released while the burst continues
    hdr(8'h00, 16'h0001, 8'h1A);
    step(1'b0, 8'h00);
    check("fs_again", frame_valid, 1'b1);
    step(1'b1, 8'hB8);
    step(1'b1, 8'h2A);
    #2 resetb = 1'b0;
    #1;
    check("async_reset", {frame_valid, line_valid, pix_we, data_type, vc, err}, 32'd0);
    @(posedge clk);
    #1 resetb = 1'b1;
    clear();
    step(1'b1, 8'h55);
    check("post_reset_sync_err", err, 4'b0001);
    step(1'b1, 8'h04);
    step(1'b0, 8'h00);
    hdr(8'h00, 16'h0001, 8'h1A);
    check("post_reset_fs", frame_valid, 1'b1);
    step(1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
